// File: rtl/inv_key_sched.sv
// -----------------------------------------------------------------------------
// inv_key_sched -- AES-128 inverse (decryption-order) key schedule.
//
// A captured cipher key is first expanded forward for ten cycles. The round-10
// key is then presented and walked backwards one round per consumer handshake,
// down to round 0, which is the original key. A one-cycle o_done pulse follows
// the acceptance of round 0.
//
// Optional feature (macro INV_KEY_LAST_LOAD_EN):
//   adds input i_key_is_last. When it is high with i_start, i_key is taken as
//   the round-10 key, the forward pass is skipped and the key is presented on
//   the next cycle.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        job request, sampled only while idle
//   i_key_is_last  (macro only) i_key is already the round-10 key
//   i_key[127:0]   cipher key, word w0 in [127:96]
//   o_busy         high whenever a job is in progress
//   o_key_valid    o_round_key / o_round_idx valid
//   i_key_ready    consumer accepts the current round key
//   o_round_key    round key, same word order as i_key (0 when not valid)
//   o_round_idx    round number 10 down to 0 (0 when not valid)
//   o_done         one-cycle pulse after round 0 is accepted
// -----------------------------------------------------------------------------

// RotWord: cyclic left rotation of a word by one byte.
module rot_word (
    input  logic [31:0] word,
    output logic [31:0] rotated
);
    assign rotated = {word[23:0], word[31:24]};
endmodule

// SubWord: AES S-box applied to each byte of a word.
module sub_word (
    input  logic [31:0] word,
    output logic [31:0] subbed
);
    // Forward S-box, entry 0x00 in the top byte, one table row per line.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset 8*(255-b); 255-b is simply ~b for a byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    assign subbed = {sbox(word[31:24]), sbox(word[23:16]),
                     sbox(word[15:8]),  sbox(word[7:0])};
endmodule

module inv_key_sched (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
`ifdef INV_KEY_LAST_LOAD_EN
    input  logic         i_key_is_last,
`endif
    input  logic [127:0] i_key,
    output logic         o_busy,
    output logic         o_key_valid,
    input  logic         i_key_ready,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round_idx,
    output logic         o_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t       state_r, state_s;
    logic [127:0] key_r, key_s;
    logic [3:0]   rnd_r, rnd_s;
    logic         valid_r, busy_r, done_r;
    logic [127:0] round_key_r, out_key_s;
    logic [3:0]   round_idx_r, out_idx_s;

    logic [31:0]  w0_s, w1_s, w2_s, w3_s;
    logic [31:0]  sw_in_s, rot_s, sub_s, rcon_s;
    logic [3:0]   rcon_idx_s;
    logic [127:0] fwd_key_s, rev_key_s;
    logic         accept_s, last_load_s;

    // Round constant in the top byte; indices outside 1..10 never get used.
    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return {c, 24'h000000};
    endfunction

`ifdef INV_KEY_LAST_LOAD_EN
    assign last_load_s = i_key_is_last;
`else
    assign last_load_s = 1'b0;
`endif

    assign w0_s     = key_r[127:96];
    assign w1_s     = key_r[95:64];
    assign w2_s     = key_r[63:32];
    assign w3_s     = key_r[31:0];
    assign accept_s = valid_r & i_key_ready;

    // Shared SubWord operand: going backwards the previous round's w3 must be
    // recovered first (w3 ^ w2), and the round constant is that of round r.
    always_comb begin
        if (state_r == ST_REV) begin
            sw_in_s    = w3_s ^ w2_s;
            rcon_idx_s = rnd_r;
        end else begin
            sw_in_s    = w3_s;
            rcon_idx_s = rnd_r + 4'd1;
        end
    end

    rot_word u_rot_word (
        .word    (sw_in_s),
        .rotated (rot_s)
    );

    sub_word u_sub_word (
        .word   (rot_s),
        .subbed (sub_s)
    );

    assign rcon_s = rcon(rcon_idx_s);

    // Forward and inverse single-round steps built on the shared SubWord.
    always_comb begin
        fwd_key_s[127:96] = w0_s ^ sub_s ^ rcon_s;
        fwd_key_s[95:64]  = w1_s ^ fwd_key_s[127:96];
        fwd_key_s[63:32]  = w2_s ^ fwd_key_s[95:64];
        fwd_key_s[31:0]   = w3_s ^ fwd_key_s[63:32];
        rev_key_s[31:0]   = w3_s ^ w2_s;
        rev_key_s[63:32]  = w2_s ^ w1_s;
        rev_key_s[95:64]  = w1_s ^ w0_s;
        rev_key_s[127:96] = w0_s ^ sub_s ^ rcon_s;
    end

    // Next-state, key register and round counter.
    always_comb begin
        state_s = state_r;
        key_s   = key_r;
        rnd_s   = rnd_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    key_s = i_key;
                    if (last_load_s) begin
                        rnd_s   = 4'd10;
                        state_s = ST_REV;
                    end else begin
                        rnd_s   = 4'd0;
                        state_s = ST_FWD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FWD: begin
                key_s = fwd_key_s;
                rnd_s = rnd_r + 4'd1;
                // Counter reaches 10 on this edge: round 10 is now held.
                if (rnd_r == 4'd9) begin
                    state_s = ST_REV;
                end else begin
                    state_s = ST_FWD;
                end
            end
            ST_REV: begin
                if (accept_s) begin
                    if (rnd_r == 4'd0) begin
                        state_s = ST_FIN;
                        key_s   = 128'd0;
                        rnd_s   = 4'd0;
                    end else begin
                        key_s = rev_key_s;
                        rnd_s = rnd_r - 4'd1;
                    end
                end else begin
                    state_s = ST_REV;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                key_s   = 128'd0;
                rnd_s   = 4'd0;
            end
        endcase
    end

    // Output payload: only the REV state exposes a key, otherwise all zero.
    always_comb begin
        if (state_s == ST_REV) begin
            out_key_s = key_s;
            out_idx_s = rnd_s;
        end else begin
            out_key_s = 128'd0;
            out_idx_s = 4'd0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            key_r       <= 128'd0;
            rnd_r       <= 4'd0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            round_key_r <= 128'd0;
            round_idx_r <= 4'd0;
        end else begin
            state_r     <= state_s;
            key_r       <= key_s;
            rnd_r       <= rnd_s;
            valid_r     <= (state_s == ST_REV);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_FIN);
            round_key_r <= out_key_s;
            round_idx_r <= out_idx_s;
        end
    end

    assign o_busy      = busy_r;
    assign o_key_valid = valid_r;
    assign o_done      = done_r;
    assign o_round_key = round_key_r;
    assign o_round_idx = round_idx_r;

endmodule

// File: doc/inv_key_sched.md
INV_KEY_SCHED -- requirements
Module: inv_key_sched

Interface
REQ-001 The module SHALL have no parameters; AES-128 only (Nk=4, 10 rounds).
REQ-002 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_start  input  1  request; sampled only in IDLE.
REQ-005 i_key  input  128  cipher key, word w0 in bits [127:96]; captured on the accepted i_start edge.
REQ-006 o_busy  output  1  high in every state except IDLE.
REQ-007 o_key_valid  output  1  o_round_key/o_round_idx valid this cycle.
REQ-008 i_key_ready  input  1  consumer accepts the current round key when it and o_key_valid are both high at a rising edge.
REQ-009 o_round_key  output  128  round key, same word order as i_key.
REQ-010 o_round_idx  output  4  round number of o_round_key: 10 down to 0.
REQ-011 o_done  output  1  one-cycle pulse after round 0 is accepted.

Function
REQ-012 States SHALL be IDLE, FWD, REV and FIN; reset enters IDLE.
REQ-013 IDLE with i_start=1 SHALL capture i_key, set the round counter to 0 and go to FWD.
REQ-014 FWD SHALL compute one forward round per cycle: w0'=w0^SubWord(RotWord(w3))^Rcon[r+1], w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-015 FWD SHALL last exactly 10 cycles, then go to REV with round 10 held; o_key_valid rises 11 cycles after the edge that samples i_start.
REQ-016 REV SHALL hold o_key_valid high and keep o_round_key/o_round_idx stable while i_key_ready is low.
REQ-017 On each REV accept with index r>0, the next cycle SHALL present round r-1: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon[r].
REQ-018 With i_key_ready tied high, REV SHALL emit 11 keys on 11 consecutive cycles.
REQ-019 The accept of round 0 SHALL move to FIN; FIN asserts o_done for one cycle and returns to IDLE.
REQ-020 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 in the top byte, with the lower three bytes zero.
REQ-021 SubWord and RotWord SHALL use the codebase's existing sub_word and rot_word blocks; there is one SubWord instance, shared by FWD and REV.
REQ-022 i_start SHALL be ignored while o_busy is high; a new job starts only from IDLE.
REQ-023 o_round_key and o_round_idx SHALL be 0 whenever o_key_valid is low.
REQ-024 i_key SHALL be don't-care after capture; changing it mid-job does not affect the job.

Reset
REQ-025 Asserting i_rst_n low SHALL immediately force IDLE, clear all key registers and the counter, and drive every output to 0, in any state.
REQ-026 A reset in the middle of FWD or REV SHALL abort the job; no o_done pulse follows.
REQ-027 The first i_start SHALL be honoured on the first rising edge after i_rst_n goes high.

Configuration
REQ-028 Macro INV_KEY_LAST_LOAD_EN, when defined, SHALL add input i_key_is_last (1 bit), sampled together with i_start.
REQ-029 With the macro defined and i_key_is_last=1, i_key SHALL be taken as the round-10 key; FWD is skipped and REV is entered directly, so o_key_valid rises 1 cycle after the i_start edge.
REQ-030 With the macro defined and i_key_is_last=0, or with the macro undefined, behaviour SHALL follow REQ-013..REQ-015, and the port SHALL be absent when the macro is undefined.

Verification
REQ-031 Test 1: i_key=2b7e151628aed2a6abf7158809cf4f3c, i_key_ready=1 -> after 11 cycles, idx 10 key d014f9a8c9ee2589e13f0cc8b6630ca6, then idx 9 key ac7766f319fadc2128d12941575c006e, ..., idx 1 key a0fafe1788542cb123a339392a6c7605, idx 0 key equals i_key, then a single o_done pulse.
REQ-032 Test 2: same key, i_key_ready toggled at random -> same 11-key sequence; key and index stay stable during stalls; exactly 11 handshakes.
REQ-033 Test 3: i_start pulsed in FWD and in REV with a different key -> ignored; output sequence is unchanged.
REQ-034 Test 4: reset asserted after the idx 6 accept -> all outputs 0 at once and no o_done; a restart yields the full sequence from idx 10.
REQ-035 Test 5 (INV_KEY_LAST_LOAD_EN): i_key=d014f9a8c9ee2589e13f0cc8b6630ca6 with i_key_is_last=1 -> idx 10 appears 1 cycle later and idx 0 equals 2b7e151628aed2a6abf7158809cf4f3c.
REQ-036 Test 6: back-to-back jobs with i_start held high through FIN -> the second job starts on the first IDLE cycle, with no lost or extra keys.
